// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch front end: PC sequencing, 1-cycle program-memory
// reads, prefetch queue, redirect/flush and range/alignment fault capture.
module mips_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    QUEUE_DEPTH  = 4,
  parameter int                    ADDR_W       = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fetch_fault,
  output logic [DATA_WIDTH-1:0] fault_pc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH:0] MEM_BYTES =
    (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);
  localparam logic [CNT_W:0] Q_LIMIT = (CNT_W+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] ret_pc_q;
  logic [DATA_WIDTH-1:0] fault_pc_q;
  logic                  fault_q;
  logic                  inflight_q;
  logic                  tag_q;
  logic                  epoch_q;
  logic [PTR_W-1:0]      rd_q;
  logic [PTR_W-1:0]      wr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DATA_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_instr [QUEUE_DEPTH];

  logic [DATA_WIDTH-1:0] offset;
  logic                  in_range;
  logic                  credit_ok;
  logic                  issue;
  logic                  fault_hit;
  logic                  push;
  logic                  pop;

  assign offset   = pc_q - TEXT_BASE;
  assign in_range = (pc_q[1:0] == 2'b00)
                 && (pc_q >= TEXT_BASE)
                 && ({1'b0, offset} < MEM_BYTES);

  // Room for the in-flight word plus one more before issuing.
  assign credit_ok = ({1'b0, cnt_q}
                   + {{CNT_W{1'b0}}, inflight_q}) < Q_LIMIT;

  // Return is dropped on a flush in its cycle or after an epoch change.
  assign push = inflight_q && (tag_q == epoch_q)
             && !redirect && !reset;

  assign instr_valid = (cnt_q != '0);
  assign pop         = instr_valid && instr_ready;

  // Next-state and issue/fault decisions; redirect outranks issue.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    fault_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_en) state_d = RUN;
      end
      RUN: begin
        if (!redirect) begin
          if (!in_range) begin
            fault_hit = 1'b1;
            state_d   = FAULT;
          end else if (fetch_en && credit_ok) begin
            issue = 1'b1;
          end
        end
      end
      FAULT: begin
        if (redirect) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // PC, in-flight tracking, queue pointers and fault capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      ret_pc_q   <= '0;
      fault_pc_q <= '0;
      fault_q    <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      epoch_q    <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_q    <= epoch_q;
        ret_pc_q <= pc_q;
      end
      if (redirect) begin
        pc_q       <= redirect_pc;
        epoch_q    <= ~epoch_q;
        fault_q    <= 1'b0;
        fault_pc_q <= '0;
        rd_q       <= '0;
        wr_q       <= '0;
        cnt_q      <= '0;
      end else begin
        if (issue) pc_q <= pc_q + DATA_WIDTH'(4);
        if (fault_hit) begin
          fault_q    <= 1'b1;
          fault_pc_q <= pc_q;
        end
        if (push) wr_q <= wr_q + PTR_W'(1);
        if (pop)  rd_q <= rd_q + PTR_W'(1);
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue storage; contents are qualified by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_q]    <= ret_pc_q;
      q_instr[wr_q] <= imem_rdata;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = issue ? offset[ADDR_W+1:2] : '0;
  assign instr       = instr_valid ? q_instr[rd_q] : '0;
  assign instr_pc    = instr_valid ? q_pc[rd_q] : '0;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: cycle vector table, directed corner
// sequences, and a random run against a program-order stream model.
module tb_mips_fetch_unit;

  localparam int          MD   = 32;
  localparam int          QD   = 4;
  localparam int          AW   = 5;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          fetch_fault;
  logic [31:0]   fault_pc;

  int tests = 0;
  int fails = 0;

  logic [31:0] rom [MD];

  mips_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_fault (fetch_fault),
    .fault_pc    (fault_pc)
  );

  always #5 clk = ~clk;

  // Registered program memory, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= rom[imem_addr];
  end

  typedef struct {
    logic        chk;
    logic        rst;
    logic        en;
    logic        rdy;
    logic        req;
    logic        val;
    logic [31:0] ins;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic chk, rst, en, rdy,
                             input logic req, val,
                             input int ins);
    vec_t t;
    t.chk = chk; t.rst = rst; t.en = en; t.rdy = rdy;
    t.req = req; t.val = val; t.ins = 32'(ins);
    return t;
  endfunction

  function automatic logic in_range(input logic [31:0] pc);
    return (pc % 4 == 0) && (pc >= BASE) && (pc < BASE + 4 * MD);
  endfunction

  function automatic logic [31:0] rom_at(input logic [31:0] pc);
    if (!in_range(pc)) return 32'hDEAD_BEEF;
    return rom[(pc - BASE) / 4];
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic to_neg(input logic r, en, rdy, rd,
                        input logic [31:0] rpc);
    reset = r; fetch_en = en; instr_ready = rdy;
    redirect = rd; redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    to_neg(1, 0, 0, 0, 0); to_pos();
    to_neg(1, 0, 0, 0, 0); to_pos();
  endtask

  initial begin
    int n;
    logic got;
    int delivered;
    logic seen_fault;
    int req_after;
    logic [31:0] exp_pc;
    int outst;
    int pops;
    logic en, rdy, rd;
    logic [31:0] rpc;
    int r;

    for (int k = 0; k < MD; k++) rom[k] = 32'(k);

    // Reset, streaming start, then stall/drain from empty.
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(v(1, 0, 1, 1, 1, 0, 0));
    for (int k = 3; k <= 10; k++)
      vecs.push_back(v(1, 0, 1, 1, 1, 1, k - 3));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(1, 0, 1, 0, 1, 1, 0));
    for (int k = 5; k <= 9; k++)
      vecs.push_back(v(1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(v(1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(v(1, 0, 1, 1, 1, 1, 1));
    for (int k = 12; k <= 17; k++)
      vecs.push_back(v(1, 0, 1, 1, 1, 1, k - 10));

    do_reset();
    foreach (vecs[i]) begin
      to_neg(vecs[i].rst, vecs[i].en, vecs[i].rdy, 0, 0);
      if (vecs[i].chk) begin
        check($sformatf("v%0d req", i),
              32'(imem_req), 32'(vecs[i].req));
        check($sformatf("v%0d valid", i),
              32'(instr_valid), 32'(vecs[i].val));
        check($sformatf("v%0d instr", i), instr,
              vecs[i].val ? vecs[i].ins : 32'h0);
        check($sformatf("v%0d pc", i), instr_pc,
              vecs[i].val ? BASE + 4 * vecs[i].ins : 32'h0);
        check($sformatf("v%0d fault", i), 32'(fetch_fault), 0);
        if (vecs[i].rst) begin
          check($sformatf("v%0d rst addr", i), 32'(imem_addr), 0);
          check($sformatf("v%0d rst fpc", i), fault_pc, 0);
        end
      end
      to_pos();
    end

    // Redirect with three queued and one return in flight.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      to_neg(0, 1, 0, 0, 0); to_pos();
    end
    to_neg(0, 1, 0, 1, BASE + 32'h40);
    check("s3 head", instr, 0);
    check("s3 req", 32'(imem_req), 0);
    to_pos();
    n = 0; got = 0;
    while (!got && n < 10) begin
      to_neg(0, 1, 1, 0, 0);
      n++;
      if (n == 1) check("s3 addr", 32'(imem_addr), 16);
      if (instr_valid) got = 1;
      else to_pos();
    end
    check("s3 valid", 32'(got), 1);
    check("s3 latency", 32'(n), 3);
    check("s3 pc", instr_pc, BASE + 32'h40);
    check("s3 instr", instr, 16);
    to_pos();

    // Run off the end of program memory.
    do_reset();
    delivered = 0; seen_fault = 0; req_after = 0;
    for (int c = 0; c < 45; c++) begin
      to_neg(0, 1, 1, 0, 0);
      if (instr_valid) begin
        check("s4 instr", instr, 32'(delivered));
        check("s4 pc", instr_pc, BASE + 4 * delivered);
        delivered++;
      end
      if (seen_fault && imem_req) req_after++;
      if (fetch_fault) seen_fault = 1;
      to_pos();
    end
    check("s4 count", 32'(delivered), 32);
    check("s4 req after", 32'(req_after), 0);
    to_neg(0, 1, 1, 1, BASE);
    check("s4 fault", 32'(fetch_fault), 1);
    check("s4 fault_pc", fault_pc, BASE + 32'h80);
    to_pos();
    to_neg(0, 1, 1, 0, 0);
    check("s4 cleared", 32'(fetch_fault), 0);
    check("s4 fpc cleared", fault_pc, 0);
    check("s4 restart req", 32'(imem_req), 1);
    check("s4 restart addr", 32'(imem_addr), 0);
    to_pos();

    // Misaligned redirect target.
    to_neg(0, 1, 1, 1, BASE + 2); to_pos();
    to_neg(0, 1, 1, 0, 0);
    check("s5 req0", 32'(imem_req), 0);
    check("s5 fault0", 32'(fetch_fault), 0);
    check("s5 valid0", 32'(instr_valid), 0);
    to_pos();
    to_neg(0, 1, 1, 0, 0);
    check("s5 fault1", 32'(fetch_fault), 1);
    check("s5 fault_pc", fault_pc, BASE + 2);
    check("s5 req1", 32'(imem_req), 0);
    to_pos();

    // Reset with a nearly full queue and a return in flight.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      to_neg(0, 1, 0, 0, 0); to_pos();
    end
    to_neg(1, 1, 0, 0, 0); to_pos();
    to_neg(0, 1, 0, 0, 0);
    check("s6 valid", 32'(instr_valid), 0);
    check("s6 req", 32'(imem_req), 0);
    check("s6 instr", instr | instr_pc, 0);
    to_pos();
    to_neg(0, 1, 0, 0, 0);
    check("s6 req2", 32'(imem_req), 1);
    check("s6 addr", 32'(imem_addr), 0);
    to_pos();
    to_neg(0, 1, 0, 0, 0);
    check("s6 no stale", 32'(instr_valid), 0);
    to_pos();
    to_neg(0, 1, 0, 0, 0);
    check("s6 first pc", instr_pc, BASE);
    check("s6 first instr", instr, 0);
    to_pos();

    // Random traffic against a program-order stream model.
    for (int k = 0; k < MD; k++) rom[k] = $urandom;
    do_reset();
    exp_pc = BASE; outst = 0; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      en  = (c < 3) ? 1'b1 : ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      rd  = (c > 3) && ($urandom_range(0, 39) == 0);
      r   = $urandom_range(0, 19);
      if (r < 14)      rpc = BASE + 4 * $urandom_range(0, MD - 1);
      else if (r < 17) rpc = BASE + 4 * $urandom_range(MD, MD + 8);
      else if (r < 18) rpc = BASE - 4;
      else rpc = BASE + 4 * $urandom_range(0, MD - 1)
               + $urandom_range(1, 3);
      to_neg(0, en, rdy, rd, rpc);
      if (instr_valid && rdy) begin
        check("rnd in range", 32'(in_range(exp_pc)), 1);
        check("rnd pc", instr_pc, exp_pc);
        check("rnd instr", instr, rom_at(exp_pc));
        exp_pc = exp_pc + 4;
        outst--;
        pops++;
      end
      if (!instr_valid) check("rnd idle bus", instr | instr_pc, 0);
      if (imem_req) outst++;
      check("rnd req w/o en", 32'(!en && imem_req), 0);
      check("rnd req in fault", 32'(fetch_fault && imem_req), 0);
      check("rnd credit", 32'(outst > QD), 0);
      if (fetch_fault && !instr_valid) begin
        check("rnd fault_pc", fault_pc, exp_pc);
        check("rnd fault oor", 32'(in_range(fault_pc)), 0);
      end
      if (rd) begin
        exp_pc = rpc;
        outst = 0;
      end
      to_pos();
    end
    check("rnd progress", 32'(pops > 300), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
